// File: rtl/pipe_pkg.sv
// Shared constants and FSM encoding for the ID->EX pipeline register.
package pipe_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 32;
  localparam int REGADDR_W_DEF = 5;
  localparam int ALUOP_W_DEF   = 8;
  localparam int ALUSEL_W_DEF  = 3;

  localparam logic [ALUOP_W_DEF-1:0]   EX_NOP     = 8'b0000_0000;
  localparam logic [ALUSEL_W_DEF-1:0]  EX_RES_NOP = 3'b000;
  localparam logic [REGADDR_W_DEF-1:0] NOPRegAddr = 5'b00000;
  localparam logic [DATA_W_DEF-1:0]    ZeroWord   = 32'h0000_0000;

  typedef enum logic {
    NORMAL    = 1'b0,
    KILL_PEND = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/id_ex_lane.sv
// One lane of the ID->EX register: load, bubble or hold its payload.
module id_ex_lane
  import pipe_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int REGADDR_W = REGADDR_W_DEF,
  parameter int ALUOP_W   = ALUOP_W_DEF,
  parameter int ALUSEL_W  = ALUSEL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 bubble,
  input  logic                 id_valid,
  input  logic [ALUOP_W-1:0]   id_aluop,
  input  logic [ALUSEL_W-1:0]  id_alusel,
  input  logic [DATA_W-1:0]    id_reg1,
  input  logic [DATA_W-1:0]    id_reg2,
  input  logic [REGADDR_W-1:0] id_wd,
  input  logic                 id_wreg,
  input  logic [ADDR_W-1:0]    id_pc,
  input  logic [ADDR_W-1:0]    offset_i,
  output logic                 ex_valid,
  output logic [ALUOP_W-1:0]   ex_aluop,
  output logic [ALUSEL_W-1:0]  ex_alusel,
  output logic [DATA_W-1:0]    ex_reg1,
  output logic [DATA_W-1:0]    ex_reg2,
  output logic [REGADDR_W-1:0] ex_wd,
  output logic                 ex_wreg,
  output logic [ADDR_W-1:0]    ex_pc,
  output logic [ADDR_W-1:0]    offset_o
);

  // An invalid slot loads as a bubble so stale fields never reach EX.
  logic clear;
  assign clear = bubble || (load && !id_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid  <= 1'b0;
      ex_aluop  <= ALUOP_W'(EX_NOP);
      ex_alusel <= ALUSEL_W'(EX_RES_NOP);
      ex_reg1   <= DATA_W'(ZeroWord);
      ex_reg2   <= DATA_W'(ZeroWord);
      ex_wd     <= REGADDR_W'(NOPRegAddr);
      ex_wreg   <= 1'b0;
      ex_pc     <= ADDR_W'(ZeroWord);
      offset_o  <= ADDR_W'(ZeroWord);
    end else if (clear) begin
      ex_valid  <= 1'b0;
      ex_aluop  <= ALUOP_W'(EX_NOP);
      ex_alusel <= ALUSEL_W'(EX_RES_NOP);
      ex_reg1   <= DATA_W'(ZeroWord);
      ex_reg2   <= DATA_W'(ZeroWord);
      ex_wd     <= REGADDR_W'(NOPRegAddr);
      ex_wreg   <= 1'b0;
      ex_pc     <= ADDR_W'(ZeroWord);
      offset_o  <= ADDR_W'(ZeroWord);
    end else if (load) begin
      ex_valid  <= 1'b1;
      ex_aluop  <= id_aluop;
      ex_alusel <= id_alusel;
      ex_reg1   <= id_reg1;
      ex_reg2   <= id_reg2;
      ex_wd     <= id_wd;
      ex_wreg   <= id_wreg;
      ex_pc     <= id_pc;
      offset_o  <= offset_i;
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// Multi-lane ID->EX register with deferred-kill FSM and saturating hold counter.
// Optional PIPE_STATS_EN adds bubble_cnt_o / flush_cnt_o event counters.
//   state     | meaning
//   NORMAL    | adv loads ID payload
//   KILL_PEND | flush hit while ID stalled; next adv is squashed
module id_ex_pipe
  import pipe_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int REGADDR_W  = REGADDR_W_DEF,
  parameter int ALUOP_W    = ALUOP_W_DEF,
  parameter int ALUSEL_W   = ALUSEL_W_DEF,
  parameter int STALL_W    = 6,
  parameter int STAGE      = 2,
  parameter int HOLD_CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES-1:0]           id_valid,
  input  logic [LANES*ALUOP_W-1:0]   id_aluop,
  input  logic [LANES*ALUSEL_W-1:0]  id_alusel,
  input  logic [LANES*DATA_W-1:0]    id_reg1,
  input  logic [LANES*DATA_W-1:0]    id_reg2,
  input  logic [LANES*REGADDR_W-1:0] id_wd,
  input  logic [LANES-1:0]           id_wreg,
  input  logic [LANES*ADDR_W-1:0]    id_pc,
  input  logic [LANES*ADDR_W-1:0]    offset_i,
  input  logic                       flush_i,
  input  logic [STALL_W-1:0]         stall_state,
  output logic [LANES-1:0]           ex_valid,
  output logic [LANES*ALUOP_W-1:0]   ex_aluop,
  output logic [LANES*ALUSEL_W-1:0]  ex_alusel,
  output logic [LANES*DATA_W-1:0]    ex_reg1,
  output logic [LANES*DATA_W-1:0]    ex_reg2,
  output logic [LANES*REGADDR_W-1:0] ex_wd,
  output logic [LANES-1:0]           ex_wreg,
  output logic [LANES*ADDR_W-1:0]    ex_pc,
  output logic [LANES*ADDR_W-1:0]    offset_o,
`ifdef PIPE_STATS_EN
  output logic [31:0]                bubble_cnt_o,
  output logic [31:0]                flush_cnt_o,
`endif
  output logic                       kill_pending_o,
  output logic [HOLD_CNT_W-1:0]      hold_cnt_o
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_MAX = '1;

  pipe_state_e               state_q, state_d;
  logic [HOLD_CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                      adv, bub, lane_load, lane_bubble;

  assign adv = !stall_state[STAGE];
  assign bub = stall_state[STAGE] && !stall_state[STAGE+1];

  always_comb begin
    state_d     = state_q;
    lane_load   = 1'b0;
    lane_bubble = 1'b0;
    hold_cnt_d  = '0;
    if (flush_i) begin
      lane_bubble = 1'b1;
      state_d     = stall_state[STAGE] ? KILL_PEND : NORMAL;
    end else if (adv) begin
      if (state_q == KILL_PEND) begin
        lane_bubble = 1'b1;
        state_d     = NORMAL;
      end else begin
        lane_load = 1'b1;
      end
    end else if (bub) begin
      lane_bubble = 1'b1;
    end else begin
      hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= NORMAL;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign kill_pending_o = (state_q == KILL_PEND);
  assign hold_cnt_o     = hold_cnt_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    id_ex_lane #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REGADDR_W(REGADDR_W),
      .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (lane_load),
      .bubble   (lane_bubble),
      .id_valid (id_valid[l]),
      .id_aluop (id_aluop[l*ALUOP_W +: ALUOP_W]),
      .id_alusel(id_alusel[l*ALUSEL_W +: ALUSEL_W]),
      .id_reg1  (id_reg1[l*DATA_W +: DATA_W]),
      .id_reg2  (id_reg2[l*DATA_W +: DATA_W]),
      .id_wd    (id_wd[l*REGADDR_W +: REGADDR_W]),
      .id_wreg  (id_wreg[l]),
      .id_pc    (id_pc[l*ADDR_W +: ADDR_W]),
      .offset_i (offset_i[l*ADDR_W +: ADDR_W]),
      .ex_valid (ex_valid[l]),
      .ex_aluop (ex_aluop[l*ALUOP_W +: ALUOP_W]),
      .ex_alusel(ex_alusel[l*ALUSEL_W +: ALUSEL_W]),
      .ex_reg1  (ex_reg1[l*DATA_W +: DATA_W]),
      .ex_reg2  (ex_reg2[l*DATA_W +: DATA_W]),
      .ex_wd    (ex_wd[l*REGADDR_W +: REGADDR_W]),
      .ex_wreg  (ex_wreg[l]),
      .ex_pc    (ex_pc[l*ADDR_W +: ADDR_W]),
      .offset_o (offset_o[l*ADDR_W +: ADDR_W])
    );
  end

`ifdef PIPE_STATS_EN
  // Counts bubbles from bub and from the deferred-kill squash, not flush bubbles.
  logic stat_bub;
  assign stat_bub = !flush_i && (bub || (adv && state_q == KILL_PEND));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (stat_bub) bubble_cnt_o <= bubble_cnt_o + 32'd1;
      if (flush_i)  flush_cnt_o  <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe (LANES=2): driver pushes model results, monitor compares.
module tb_id_ex_pipe;

  localparam int L   = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int RW  = 5;
  localparam int OW  = 8;
  localparam int SW  = 3;
  localparam int STW = 6;
  localparam int STG = 2;
  localparam int HW  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [L-1:0]    id_valid = '0;
  logic [L*OW-1:0] id_aluop = '0;
  logic [L*SW-1:0] id_alusel = '0;
  logic [L*DW-1:0] id_reg1 = '0, id_reg2 = '0;
  logic [L*RW-1:0] id_wd = '0;
  logic [L-1:0]    id_wreg = '0;
  logic [L*AW-1:0] id_pc = '0, offset_i = '0;
  logic            flush_i = 1'b0;
  logic [STW-1:0]  stall_state = '0;

  logic [L-1:0]    ex_valid;
  logic [L*OW-1:0] ex_aluop;
  logic [L*SW-1:0] ex_alusel;
  logic [L*DW-1:0] ex_reg1, ex_reg2;
  logic [L*RW-1:0] ex_wd;
  logic [L-1:0]    ex_wreg;
  logic [L*AW-1:0] ex_pc, offset_o;
  logic            kill_pending_o;
  logic [HW-1:0]   hold_cnt_o;
`ifdef PIPE_STATS_EN
  logic [31:0]     bubble_cnt_o, flush_cnt_o;
`endif

  id_ex_pipe #(
    .LANES(L), .DATA_W(DW), .ADDR_W(AW), .REGADDR_W(RW), .ALUOP_W(OW),
    .ALUSEL_W(SW), .STALL_W(STW), .STAGE(STG), .HOLD_CNT_W(HW)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_aluop(id_aluop), .id_alusel(id_alusel),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
    .id_pc(id_pc), .offset_i(offset_i), .flush_i(flush_i), .stall_state(stall_state),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_pc(ex_pc), .offset_o(offset_o),
`ifdef PIPE_STATS_EN
    .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o),
`endif
    .kill_pending_o(kill_pending_o), .hold_cnt_o(hold_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [L-1:0]    valid;
    logic [L*OW-1:0] aluop;
    logic [L*SW-1:0] alusel;
    logic [L*DW-1:0] reg1;
    logic [L*DW-1:0] reg2;
    logic [L*RW-1:0] wd;
    logic [L-1:0]    wreg;
    logic [L*AW-1:0] pc;
    logic [L*AW-1:0] off;
    logic            kill;
    logic [HW-1:0]   hold;
    logic [31:0]     bcnt;
    logic [31:0]     fcnt;
  } exp_t;

  exp_t m = '0;
  exp_t q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Reference: every bubble field is zero; pending-kill is a single flag.
  task automatic model_step();
    logic stl, stl1, clear;
    stl   = stall_state[STG];
    stl1  = stall_state[STG+1];
    clear = 1'b0;
    if (!rst) begin
      m = '0;
    end else if (flush_i) begin
      clear  = 1'b1;
      m.kill = stl;
      m.hold = '0;
      m.fcnt = m.fcnt + 32'd1;
    end else if (!stl) begin
      m.hold = '0;
      if (m.kill) begin
        clear  = 1'b1;
        m.kill = 1'b0;
        m.bcnt = m.bcnt + 32'd1;
      end else begin
        for (int l = 0; l < L; l++) begin
          m.valid[l]             = id_valid[l];
          m.aluop[l*OW +: OW]    = id_valid[l] ? id_aluop[l*OW +: OW] : '0;
          m.alusel[l*SW +: SW]   = id_valid[l] ? id_alusel[l*SW +: SW] : '0;
          m.reg1[l*DW +: DW]     = id_valid[l] ? id_reg1[l*DW +: DW] : '0;
          m.reg2[l*DW +: DW]     = id_valid[l] ? id_reg2[l*DW +: DW] : '0;
          m.wd[l*RW +: RW]       = id_valid[l] ? id_wd[l*RW +: RW] : '0;
          m.wreg[l]              = id_valid[l] && id_wreg[l];
          m.pc[l*AW +: AW]       = id_valid[l] ? id_pc[l*AW +: AW] : '0;
          m.off[l*AW +: AW]      = id_valid[l] ? offset_i[l*AW +: AW] : '0;
        end
      end
    end else if (!stl1) begin
      clear  = 1'b1;
      m.hold = '0;
      m.bcnt = m.bcnt + 32'd1;
    end else if (m.hold != 4'd15) begin
      m.hold = m.hold + 4'd1;
    end
    if (clear) begin
      m.valid = '0; m.aluop = '0; m.alusel = '0; m.reg1 = '0; m.reg2 = '0;
      m.wd = '0; m.wreg = '0; m.pc = '0; m.off = '0;
    end
  endtask

  task automatic cyc();
    model_step();
    q.push_back(m);
    @(negedge clk);
  endtask

  task automatic rand_fields();
    id_valid  = L'($urandom);
    id_aluop  = (L*OW)'($urandom);
    id_alusel = (L*SW)'($urandom);
    id_reg1   = {$urandom, $urandom};
    id_reg2   = {$urandom, $urandom};
    id_wd     = (L*RW)'($urandom);
    id_wreg   = L'($urandom);
    id_pc     = {$urandom, $urandom};
    offset_i  = {$urandom, $urandom};
  endtask

  exp_t e;
  logic [291:0] act_pl, exp_pl;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e      = q.pop_front();
        act_pl = {ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_pc, offset_o};
        exp_pl = {e.valid, e.aluop, e.alusel, e.reg1, e.reg2, e.wd, e.wreg, e.pc, e.off};
        n_vec++;
        if (act_pl !== exp_pl) begin
          n_mis++;
          $display("FAIL payload @%0t got %h exp %h", $time, act_pl, exp_pl);
        end
        n_vec++;
        if (kill_pending_o !== e.kill) begin
          n_mis++;
          $display("FAIL kill_pending @%0t got %b exp %b", $time, kill_pending_o, e.kill);
        end
        n_vec++;
        if (hold_cnt_o !== e.hold) begin
          n_mis++;
          $display("FAIL hold_cnt @%0t got %0d exp %0d", $time, hold_cnt_o, e.hold);
        end
`ifdef PIPE_STATS_EN
        n_vec++;
        if (bubble_cnt_o !== e.bcnt || flush_cnt_o !== e.fcnt) begin
          n_mis++;
          $display("FAIL stats @%0t got b=%0d f=%0d exp b=%0d f=%0d", $time,
                   bubble_cnt_o, flush_cnt_o, e.bcnt, e.fcnt);
        end
`endif
      end
    end
  end

  initial begin
    int sel;
    #1 rst = 1'b0;
    id_valid = 2'b11;
    id_pc    = {32'h0000_0300, 32'h0000_0100};
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    stall_state = 6'b000100; id_wreg = 2'b11; id_wd = {5'd5, 5'd5};
    cyc();
    stall_state = 6'b000000; id_aluop = 16'hA55A; id_reg1 = {32'h1234_5678, 32'hDEAD_BEEF};
    cyc();
    stall_state = 6'b001100; id_pc = {32'h0000_0308, 32'h0000_0108};
    repeat (20) cyc();
    stall_state = 6'b000000;
    cyc();
    flush_i = 1'b1; stall_state = 6'b000100;
    cyc();
    flush_i = 1'b0; stall_state = 6'b000000; id_pc = {32'h0, 32'h0000_0200};
    cyc();
    id_pc = {32'h0, 32'h0000_0204};
    cyc();
    flush_i = 1'b1; id_valid = 2'b11;
    cyc();
    flush_i = 1'b0; id_valid = 2'b01; id_wreg = 2'b10;
    cyc();
    stall_state = 6'b000100;
    repeat (3) cyc();
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 99) != 0);
      flush_i = ($urandom_range(0, 7) == 0);
      sel     = $urandom_range(0, 3);
      case (sel)
        0:       stall_state = 6'b000000;
        1:       stall_state = 6'b000100;
        2:       stall_state = 6'b001100;
        default: stall_state = STW'($urandom);
      endcase
      rand_fields();
      cyc();
    end
    rst = 1'b1; flush_i = 1'b0; stall_state = '0;
    cyc();
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
